// File: rtl/gpio_checkpoint_emitter.sv
// GPIO checkpoint transmitter: FIFO-buffered (code, value) pairs presented on mprj_io
// with the value settled before its code appears. Option macro: CHECKPOINT_STICKY_LAST_EN.
module gpio_checkpoint_emitter #(
  parameter int          DEPTH        = 4,
  parameter int          SETUP_CYCLES = 2,
  parameter int          HOLD_CYCLES  = 16,
  parameter logic [37:0] OEB_MASK     = 38'h0000000008
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        en,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [5:0]  wr_code,
  input  logic [31:0] wr_data,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb,
  output logic        busy,
  output logic        overflow,
  output logic        bad_code
);

  // state | meaning
  // IDLE  | nothing presented; pops the FIFO head as soon as one exists
  // SETUP | value driven with code 0 while the counter runs down
  // SHOW  | code and value both driven for the hold time
  typedef enum logic [1:0] {IDLE, SETUP, SHOW} state_t;

  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);

  logic [5:0]    code_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop, cnt_zero;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    code_q, pend_code;
  logic [31:0]   data_q;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign wr_ready = ~full;
  assign push     = wr_valid & ~full & en & (wr_code != 6'd0);
  assign cnt_zero = (cnt == '0);
  assign pop      = en & ~empty & ((state == IDLE) | ((state == SHOW) & cnt_zero));

  assign io_out = {code_q, data_q} & ~OEB_MASK;
  assign io_oeb = {38{~en}} | OEB_MASK;
  assign busy   = ~empty | (state != IDLE);

  always_ff @(posedge clock) begin
    if (push) begin
      code_mem[wr_ptr[AW-1:0]] <= wr_code;
      data_mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      code_q    <= '0;
      pend_code <= '0;
      data_q    <= '0;
    end else if (!en) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      code_q    <= '0;
      pend_code <= '0;
      data_q    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            data_q    <= data_mem[rd_ptr[AW-1:0]];
            pend_code <= code_mem[rd_ptr[AW-1:0]];
            code_q    <= '0;
            cnt       <= SETUP_LOAD;
            state     <= SETUP;
          end
`ifndef CHECKPOINT_STICKY_LAST_EN
          else begin
            code_q <= '0;
          end
`endif
        end
        SETUP: begin
          if (cnt_zero) begin
            code_q <= pend_code;
            cnt    <= HOLD_LOAD;
            state  <= SHOW;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHOW: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else if (pop) begin
            // next entry: value and code change on the same edge, code goes to 0
            data_q    <= data_mem[rd_ptr[AW-1:0]];
            pend_code <= code_mem[rd_ptr[AW-1:0]];
            code_q    <= '0;
            cnt       <= SETUP_LOAD;
            state     <= SETUP;
          end else begin
            state <= IDLE;
`ifndef CHECKPOINT_STICKY_LAST_EN
            code_q <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // sticky error flags survive en low; only reset clears them
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      overflow <= 1'b0;
      bad_code <= 1'b0;
    end else begin
      if (wr_valid && full)            overflow <= 1'b1;
      if (wr_valid && wr_code == 6'd0) bad_code <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gpio_checkpoint_emitter.sv
// Bench for gpio_checkpoint_emitter: directed and random writes checked each cycle
// against a schedule model (pop edge of each entry derived from the timing rules).
module tb_gpio_checkpoint_emitter;
  localparam int DEPTH = 4;
  localparam int SC    = 2;
  localparam int HC    = 16;
  localparam logic [37:0] MASK = 38'h0000000008;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        en = 1'b1;
  logic        wr_valid = 1'b0;
  logic [5:0]  wr_code = '0;
  logic [31:0] wr_data = '0;
  logic        wr_ready, busy, overflow, bad_code;
  logic [37:0] io_out, io_oeb;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int          t;
    int          p;
    logic [5:0]  code;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   edge_n = 0;
  bit   m_ovf = 1'b0;
  bit   m_bad = 1'b0;

  gpio_checkpoint_emitter #(
    .DEPTH(DEPTH), .SETUP_CYCLES(SC), .HOLD_CYCLES(HC), .OEB_MASK(MASK)
  ) dut (
    .clock(clock), .resetb(resetb), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_code(wr_code), .wr_data(wr_data), .io_out(io_out), .io_oeb(io_oeb),
    .busy(busy), .overflow(overflow), .bad_code(bad_code)
  );

  always #5 clock = ~clock;

  // entries sitting in the FIFO after edge e
  function automatic int fifo_cnt(int e);
    int n = 0;
    foreach (q[i]) if (q[i].t <= e && e < q[i].p) n++;
    return n;
  endfunction

  function automatic bit busy_at(int e);
    foreach (q[i]) if (q[i].t <= e && e < q[i].p + SC + HC) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [37:0] pins_at(int e);
    logic [5:0]  c = '0;
    logic [31:0] d = '0;
    int          k = -1;
    foreach (q[i]) if (q[i].p <= e) k = i;
    if (k >= 0) begin
      d = q[k].data;
      if (e >= q[k].p + SC && e < q[k].p + SC + HC) c = q[k].code;
`ifdef CHECKPOINT_STICKY_LAST_EN
      else if (e >= q[k].p + SC + HC) c = q[k].code;
`endif
    end
    return {c, d} & ~MASK;
  endfunction

  task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("io_out", io_out, pins_at(edge_n));
    chk("io_oeb", io_oeb, en ? MASK : {38{1'b1}});
    chk("busy", {37'd0, busy}, {37'd0, busy_at(edge_n)});
    chk("wr_ready", {37'd0, wr_ready}, {37'd0, fifo_cnt(edge_n) < DEPTH});
    chk("overflow", {37'd0, overflow}, {37'd0, m_ovf});
    chk("bad_code", {37'd0, bad_code}, {37'd0, m_bad});
  endtask

  task automatic step(input bit v, input logic [5:0] c, input logic [31:0] d, input bit e_in);
    int t, cnt, last_end, pp;
    wr_valid = v;
    wr_code  = c;
    wr_data  = d;
    en       = e_in;
    t   = edge_n + 1;
    cnt = fifo_cnt(edge_n);
    if (v && cnt == DEPTH) m_ovf = 1'b1;
    if (v && c == 6'd0)    m_bad = 1'b1;
    if (!e_in) begin
      q.delete();
    end else if (v && c != 6'd0 && cnt < DEPTH) begin
      last_end = (q.size() > 0) ? q[q.size()-1].p + SC + HC : 0;
      pp = (t + 1 > last_end) ? t + 1 : last_end;
      q.push_back('{t, pp, c, d});
    end
    @(posedge clock);
    edge_n++;
    @(negedge clock);
    wr_valid = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'd0, 32'd0, 1'b1);
  endtask

  initial begin
    int r;
    bit v, e_in;
    logic [5:0]  c;
    logic [31:0] d;

    // reset values
    repeat (2) @(negedge clock);
    chk("rst_io_oeb", io_oeb, 38'h0000000008);
    chk("rst_io_out", io_out, 38'd0);
    chk("rst_wr_ready", {37'd0, wr_ready}, 38'd1);
    chk("rst_busy", {37'd0, busy}, 38'd0);
    resetb = 1'b1;
    idle(2);

    // single write: value first, code after the setup cycles, held for the hold time
    step(1'b1, 6'h01, 32'hdcba7cfb, 1'b1);
    idle(1);
    chk("first_val", {6'd0, io_out[31:0]}, {6'd0, 32'hdcba7cf3});
    chk("first_setup_code", {32'd0, io_out[37:32]}, 38'd0);
    idle(2);
    chk("first_code", {32'd0, io_out[37:32]}, 38'h01);
    chk("csb_out", {37'd0, io_out[3]}, 38'd0);
    chk("csb_oeb", {37'd0, io_oeb[3]}, 38'd1);
    idle(15);
    chk("first_code_last", {32'd0, io_out[37:32]}, 38'h01);
    idle(1);
    chk("first_code_end", {32'd0, io_out[37:32]}, 38'd0);
    idle(4);

    // back-to-back writes, including two equal values
    step(1'b1, 6'h02, 32'h19, 1'b1);
    step(1'b1, 6'h03, 32'h0f, 1'b1);
    step(1'b1, 6'h04, 32'h0f, 1'b1);
    step(1'b1, 6'h05, 32'h12bc, 1'b1);
    idle(80);

    // fill the FIFO while the FSM sits in SHOW; fifth write must be refused
    step(1'b1, 6'h20, 32'h1111, 1'b1);
    idle(5);
    step(1'b1, 6'h21, 32'h2222, 1'b1);
    step(1'b1, 6'h22, 32'h3333, 1'b1);
    step(1'b1, 6'h23, 32'h4444, 1'b1);
    step(1'b1, 6'h24, 32'h5555, 1'b1);
    chk("full_ready", {37'd0, wr_ready}, 38'd0);
    step(1'b1, 6'h25, 32'h6666, 1'b1);
    chk("ovf_set", {37'd0, overflow}, 38'd1);
    idle(110);

    // reserved code
    step(1'b1, 6'h00, 32'h0a, 1'b1);
    chk("bad_set", {37'd0, bad_code}, 38'd1);
    chk("bad_busy", {37'd0, busy}, 38'd0);

    // en dropped during SHOW
    step(1'b1, 6'h10, 32'h0a, 1'b1);
    idle(8);
    step(1'b0, 6'h00, 32'd0, 1'b0);
    chk("en_oeb", io_oeb, {38{1'b1}});
    chk("en_code", {32'd0, io_out[37:32]}, 38'd0);
    chk("en_busy", {37'd0, busy}, 38'd0);
    idle(4);

    // random traffic with occasional enable drops
    for (int i = 0; i < 300; i++) begin
      r    = $urandom_range(0, 99);
      v    = (r < 35);
      c    = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      d    = $urandom;
      e_in = ($urandom_range(0, 49) != 0);
      step(v, c, d, e_in);
    end
    idle(100);

    // asynchronous reset in the middle of an emission
    step(1'b1, 6'h2a, 32'hcafe0000, 1'b1);
    idle(6);
    #2 resetb = 1'b0;
    #1;
    chk("arst_io_out", io_out, 38'd0);
    chk("arst_busy", {37'd0, busy}, 38'd0);
    chk("arst_ovf", {37'd0, overflow}, 38'd0);
    chk("arst_bad", {37'd0, bad_code}, 38'd0);
    chk("arst_ready", {37'd0, wr_ready}, 38'd1);
    q.delete();
    m_ovf = 1'b0;
    m_bad = 1'b0;
    @(negedge clock);
    resetb = 1'b1;
    step(1'b1, 6'h3f, 32'h600dbeef, 1'b1);
    idle(24);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
